// File: rtl/reorder_buffer_mw_pkg.sv
// Shared types for the multi-issue reorder buffer: op classes, ROB entry
// payload, retire-scan stop reasons and small decode helpers.
package rob_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int PHY_WIDTH  = 6;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JUMP,
        OP_SYSTEM
    } op_class_t;

    typedef struct packed {
        logic [4:0]            rd_arch;
        logic [PHY_WIDTH-1:0]  rd_phy_old;
        logic [PHY_WIDTH-1:0]  rd_phy_new;
        op_class_t             op;
        logic [ADDR_WIDTH-1:0] pc;
    } rob_entry_t;

    typedef enum logic [1:0] {
        STOP_NONE,
        STOP_NOT_READY,
        STOP_CTRL,
        STOP_MISPREDICT
    } stop_reason_t;

    function automatic logic op_is_ctrl(op_class_t op);
        return (op == OP_BRANCH) || (op == OP_JUMP);
    endfunction

    // Stores and branches have no destination; x0 is never renamed.
    function automatic logic op_writes_rd(rob_entry_t e);
        return (e.rd_arch != 5'd0) && (e.op != OP_STORE) && (e.op != OP_BRANCH);
    endfunction

endpackage

// File: rtl/reorder_buffer_mw_if.sv
// Dispatch / writeback / retire bundle of the reorder buffer.
// master = dispatch+writeback producer side, slave = the ROB itself.
interface reorder_buffer_mw_if
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH      = 5,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int WB_PORTS       = 4
);
    logic [DISPATCH_WIDTH-1:0]                dispatch_valid;
    rob_entry_t [DISPATCH_WIDTH-1:0]          dispatch_entry;
    logic                                     dispatch_ready;
    logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0] dispatch_rob_id;

    logic [WB_PORTS-1:0]                      wb_valid;
    logic [WB_PORTS-1:0][ROB_WIDTH-1:0]       wb_rob_id;
    logic [WB_PORTS-1:0]                      wb_is_ctrl;
    logic [WB_PORTS-1:0]                      wb_mispredict;
    logic [WB_PORTS-1:0]                      wb_taken;
    logic [WB_PORTS-1:0][ADDR_WIDTH-1:0]      wb_target;

    logic [RETIRE_WIDTH-1:0]                  retire_valid;
    rob_entry_t [RETIRE_WIDTH-1:0]            retire_entry;
    logic [RETIRE_WIDTH-1:0]                  retire_pr_free;
    logic [RETIRE_WIDTH-1:0]                  retire_store;

    logic                                     btb_update_valid;
    logic [ADDR_WIDTH-1:0]                    btb_update_pc;
    logic                                     btb_update_taken;
    logic [ADDR_WIDTH-1:0]                    btb_update_target;

    logic                                     redirect_valid;
    logic [ADDR_WIDTH-1:0]                    redirect_pc;
    logic [ROB_WIDTH:0]                       rob_count;
    logic                                     rob_empty;

    modport master (
        output dispatch_valid, dispatch_entry,
        output wb_valid, wb_rob_id, wb_is_ctrl, wb_mispredict, wb_taken, wb_target,
        input  dispatch_ready, dispatch_rob_id,
        input  retire_valid, retire_entry, retire_pr_free, retire_store,
        input  btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        input  redirect_valid, redirect_pc, rob_count, rob_empty
    );

    modport slave (
        input  dispatch_valid, dispatch_entry,
        input  wb_valid, wb_rob_id, wb_is_ctrl, wb_mispredict, wb_taken, wb_target,
        output dispatch_ready, dispatch_rob_id,
        output retire_valid, retire_entry, retire_pr_free, retire_store,
        output btb_update_valid, btb_update_pc, btb_update_taken, btb_update_target,
        output redirect_valid, redirect_pc, rob_count, rob_empty
    );

endinterface

// File: rtl/reorder_buffer_mw_retire_select.sv
// In-order retire scan over the RETIRE_WIDTH oldest entries.
// Ports: per-slot valid/finished/ctrl/mispredict in; retire_valid, count, stop reason out.
module rob_retire_select
    import rob_pkg::*;
#(
    parameter int RETIRE_WIDTH = 2,
    parameter int CNT_W        = 6
) (
    input  logic [RETIRE_WIDTH-1:0] ent_valid,
    input  logic [RETIRE_WIDTH-1:0] finished,
    input  logic [RETIRE_WIDTH-1:0] is_ctrl,
    input  logic [RETIRE_WIDTH-1:0] mispredict,
    output logic [RETIRE_WIDTH-1:0] retire_valid,
    output logic [CNT_W-1:0]        retire_cnt,
    output stop_reason_t            stop
);
    logic go;

    // A control op ends the group so only one BTB update leaves per cycle;
    // a mispredict ends it because everything younger is wrong-path.
    always_comb begin
        go           = 1'b1;
        retire_valid = '0;
        retire_cnt   = '0;
        stop         = STOP_NONE;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (go) begin
                if (ent_valid[i] && finished[i]) begin
                    retire_valid[i] = 1'b1;
                    retire_cnt      = retire_cnt + CNT_W'(1);
                    if (mispredict[i]) begin
                        go   = 1'b0;
                        stop = STOP_MISPREDICT;
                    end else if (is_ctrl[i]) begin
                        go   = 1'b0;
                        stop = STOP_CTRL;
                    end
                end else begin
                    go   = 1'b0;
                    stop = STOP_NOT_READY;
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mw.sv
// Multi-issue reorder buffer: dispatch, writeback completion, in-order retire, mispredict redirect.
// Ports: clk, rst (async high), flush, bus (slave modport). ROB_PERF_EN adds perf counter outputs.
module reorder_buffer_mw #(
    parameter int NUM_ENTRY      = 32,
    parameter int ROB_WIDTH      = 5,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int WB_PORTS       = 4,
    parameter int PHY_WIDTH      = 6,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    reorder_buffer_mw_if.slave bus
`ifdef ROB_PERF_EN
    ,
    output logic [63:0]        perf_retired,
    output logic [31:0]        perf_full_cycles,
    output logic [31:0]        perf_mispredicts
`endif
);
    import rob_pkg::*;

    localparam int EW = 5 + 2 * PHY_WIDTH + 3 + ADDR_WIDTH;
    localparam int CW = ROB_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(NUM_ENTRY);
    localparam logic [CW-1:0] DW   = CW'(DISPATCH_WIDTH);

    logic [EW-1:0]         mem [NUM_ENTRY];
    logic [ADDR_WIDTH-1:0] tgt [NUM_ENTRY];
    logic [NUM_ENTRY-1:0]  ent_valid, fin, mp, tkn;
    logic [ROB_WIDTH-1:0]  head, tail;
    logic [CW-1:0]         count;
    logic                  redir_q;
    logic [ADDR_WIDTH-1:0] redir_pc_q;

    logic [ROB_WIDTH-1:0]    hidx [RETIRE_WIDTH];
    rob_entry_t              he [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] hv, hf, hc, hm, rv;
    logic [CW-1:0]           ret_cnt, disp_cnt;
    stop_reason_t            stop;
    logic                    mp_clear, disp_fire;
    logic [ADDR_WIDTH-1:0]   mp_pc;

    always_comb begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            hidx[i] = head + ROB_WIDTH'(i);
            he[i]   = rob_entry_t'(mem[hidx[i]]);
            hv[i]   = ent_valid[hidx[i]];
            hf[i]   = fin[hidx[i]];
            hc[i]   = op_is_ctrl(he[i].op);
            hm[i]   = mp[hidx[i]];
        end
    end

    rob_retire_select #(
        .RETIRE_WIDTH(RETIRE_WIDTH),
        .CNT_W       (CW)
    ) u_sel (
        .ent_valid   (hv),
        .finished    (hf),
        .is_ctrl     (hc),
        .mispredict  (hm),
        .retire_valid(rv),
        .retire_cnt  (ret_cnt),
        .stop        (stop)
    );

    assign mp_clear           = (stop == STOP_MISPREDICT);
    assign bus.dispatch_ready = (FULL - count) >= DW;
    assign disp_fire          = bus.dispatch_ready && !flush && !mp_clear;
    assign bus.rob_count      = count;
    assign bus.rob_empty      = (count == '0);
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redir_pc_q;

    always_comb begin
        disp_cnt = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            bus.dispatch_rob_id[i] = tail + ROB_WIDTH'(i);
            if (disp_fire && bus.dispatch_valid[i])
                disp_cnt = disp_cnt + CW'(1);
        end
    end

    always_comb begin
        bus.btb_update_valid  = 1'b0;
        bus.btb_update_pc     = '0;
        bus.btb_update_taken  = 1'b0;
        bus.btb_update_target = '0;
        mp_pc                 = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            bus.retire_valid[i]   = rv[i];
            bus.retire_entry[i]   = rv[i] ? he[i] : '0;
            bus.retire_pr_free[i] = rv[i] && op_writes_rd(he[i]);
            bus.retire_store[i]   = rv[i] && (he[i].op == OP_STORE);
            if (rv[i] && hc[i]) begin
                bus.btb_update_valid  = 1'b1;
                bus.btb_update_pc     = he[i].pc;
                bus.btb_update_taken  = tkn[hidx[i]];
                bus.btb_update_target = tgt[hidx[i]];
            end
            if (rv[i] && hm[i])
                mp_pc = tkn[hidx[i]] ? tgt[hidx[i]] : he[i].pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_valid  <= '0;
            fin        <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_valid  <= '0;
            fin        <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else if (mp_clear) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_valid  <= '0;
            fin        <= '0;
            redir_q    <= 1'b1;
            redir_pc_q <= mp_pc;
        end else begin
            redir_q <= 1'b0;
            tail    <= tail + disp_cnt[ROB_WIDTH-1:0];
            head    <= head + ret_cnt[ROB_WIDTH-1:0];
            count   <= count + disp_cnt - ret_cnt;
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (disp_fire && bus.dispatch_valid[i]) begin
                    ent_valid[tail + ROB_WIDTH'(i)] <= 1'b1;
                    fin[tail + ROB_WIDTH'(i)]       <= 1'b0;
                end
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid[p] && ent_valid[bus.wb_rob_id[p]])
                    fin[bus.wb_rob_id[p]] <= 1'b1;
            end
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (rv[i])
                    ent_valid[hidx[i]] <= 1'b0;
            end
        end
    end

    // Payload RAM: contents only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (disp_fire && bus.dispatch_valid[i]) begin
                mem[tail + ROB_WIDTH'(i)] <= bus.dispatch_entry[i];
                mp[tail + ROB_WIDTH'(i)]  <= 1'b0;
            end
        end
        // Later ports overwrite earlier ones on duplicate ids.
        for (int p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_valid[p] && bus.wb_is_ctrl[p] && ent_valid[bus.wb_rob_id[p]]) begin
                mp[bus.wb_rob_id[p]]  <= bus.wb_mispredict[p];
                tkn[bus.wb_rob_id[p]] <= bus.wb_taken[p];
                tgt[bus.wb_rob_id[p]] <= bus.wb_target[p];
            end
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired     <= '0;
            perf_full_cycles <= '0;
            perf_mispredicts <= '0;
        end else begin
            perf_retired <= perf_retired + 64'(ret_cnt);
            if ((bus.dispatch_valid != '0) && !bus.dispatch_ready)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if (mp_clear)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Directed bench for reorder_buffer_mw: fill/full, out-of-order completion,
// wrap steady state, mispredict redirect, BTB training, flush and async reset.
module tb_reorder_buffer_mw;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reorder_buffer_mw_if #(
        .ROB_WIDTH(5), .DISPATCH_WIDTH(2), .RETIRE_WIDTH(2), .WB_PORTS(4)
    ) bus ();

    reorder_buffer_mw #(
        .NUM_ENTRY(32), .ROB_WIDTH(5), .DISPATCH_WIDTH(2), .RETIRE_WIDTH(2),
        .WB_PORTS(4), .PHY_WIDTH(6), .ADDR_WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rob_entry_t mk(op_class_t op, logic [31:0] pc, logic [4:0] rd);
        rob_entry_t e;
        e.rd_arch    = rd;
        e.rd_phy_old = 6'(rd) + 6'd32;
        e.rd_phy_new = 6'(rd);
        e.op         = op;
        e.pc         = pc;
        return e;
    endfunction

    task automatic idle();
        bus.dispatch_valid = '0;
        bus.dispatch_entry = '0;
        bus.wb_valid       = '0;
        bus.wb_rob_id      = '0;
        bus.wb_is_ctrl     = '0;
        bus.wb_mispredict  = '0;
        bus.wb_taken       = '0;
        bus.wb_target      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        flush = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic disp(input rob_entry_t e0, input rob_entry_t e1);
        bus.dispatch_valid    = 2'b11;
        bus.dispatch_entry[0] = e0;
        bus.dispatch_entry[1] = e1;
    endtask

    task automatic wb(input int p, input logic [4:0] id, input logic ctrl,
                      input logic mis, input logic tk, input logic [31:0] t);
        bus.wb_valid[p]      = 1'b1;
        bus.wb_rob_id[p]     = id;
        bus.wb_is_ctrl[p]    = ctrl;
        bus.wb_mispredict[p] = mis;
        bus.wb_taken[p]      = tk;
        bus.wb_target[p]     = t;
    endtask

    function automatic logic [31:0] pcs(int s);
        return 32'h1000 + 32'(s) * 32'd4;
    endfunction

    initial begin
        // Reset state and fill to full
        do_reset();
        chk("rst_count", 64'(bus.rob_count), 0);
        chk("rst_empty", 64'(bus.rob_empty), 1);
        chk("rst_ready", 64'(bus.dispatch_ready), 1);
        chk("rst_rv", 64'(bus.retire_valid), 0);
        chk("rst_redir", 64'(bus.redirect_valid), 0);
        for (int k = 0; k < 16; k++) begin
            disp(mk(OP_ALU, pcs(2 * k), 5'd1), mk(OP_ALU, pcs(2 * k + 1), 5'd2));
            if (k == 0 || k == 15) begin
                chk("fill_id0", 64'(bus.dispatch_rob_id[0]), 64'(2 * k));
                chk("fill_id1", 64'(bus.dispatch_rob_id[1]), 64'(2 * k + 1));
            end
            step();
        end
        chk("full_count", 64'(bus.rob_count), 32);
        chk("full_ready", 64'(bus.dispatch_ready), 0);
        step();
        chk("full_hold", 64'(bus.rob_count), 32);
        chk("full_tail", 64'(bus.dispatch_rob_id[0]), 0);
        chk("full_rv", 64'(bus.retire_valid), 0);

        // Reverse-order completion
        do_reset();
        disp(mk(OP_ALU, 32'h300, 5'd1), mk(OP_ALU, 32'h304, 5'd2));
        step();
        disp(mk(OP_STORE, 32'h308, 5'd5), mk(OP_ALU, 32'h30c, 5'd0));
        step();
        for (int id = 3; id >= 0; id--) begin
            idle();
            wb(0, 5'(id), 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            idle();
            if (id != 0)
                chk("rev_wait", 64'(bus.retire_valid), 0);
        end
        chk("rev_rv1", 64'(bus.retire_valid), 2'b11);
        chk("rev_free1", 64'(bus.retire_pr_free), 2'b11);
        chk("rev_st1", 64'(bus.retire_store), 2'b00);
        chk("rev_pc1", 64'(bus.retire_entry[0].pc), 32'h300);
        step();
        chk("rev_rv2", 64'(bus.retire_valid), 2'b11);
        chk("rev_st2", 64'(bus.retire_store), 2'b01);
        chk("rev_free2", 64'(bus.retire_pr_free), 2'b00);
        chk("rev_pc2", 64'(bus.retire_entry[1].pc), 32'h30c);
        step();
        chk("rev_empty", 64'(bus.rob_empty), 1);

        // Steady state across the 31->0 wrap
        do_reset();
        for (int c = 0; c < 20; c++) begin
            idle();
            disp(mk(OP_ALU, pcs(2 * c), 5'd3), mk(OP_ALU, pcs(2 * c + 1), 5'd4));
            if (c > 0) begin
                wb(0, 5'(2 * c - 2), 1'b0, 1'b0, 1'b0, 32'h0);
                wb(1, 5'(2 * c - 1), 1'b0, 1'b0, 1'b0, 32'h0);
            end
            if (c >= 2) begin
                chk("ss_count", 64'(bus.rob_count), 4);
                chk("ss_rv", 64'(bus.retire_valid), 2'b11);
                chk("ss_pc0", 64'(bus.retire_entry[0].pc), 64'(pcs(2 * c - 4)));
                chk("ss_pc1", 64'(bus.retire_entry[1].pc), 64'(pcs(2 * c - 3)));
                chk("ss_id", 64'(bus.dispatch_rob_id[0]), 64'((2 * c) % 32));
            end
            step();
        end

        // Mispredicted branch at id5
        do_reset();
        for (int k = 0; k < 4; k++) begin
            disp(mk((2 * k == 5) ? OP_BRANCH : OP_ALU, pcs(2 * k), 5'd1),
                 mk((2 * k + 1 == 5) ? OP_BRANCH : OP_ALU, pcs(2 * k + 1), 5'd1));
            step();
        end
        idle();
        for (int p = 0; p < 4; p++)
            wb(p, 5'(p), 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        wb(0, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        step();
        step();
        chk("mp_pre_count", 64'(bus.rob_count), 3);
        chk("mp_pre_rv", 64'(bus.retire_valid), 0);
        wb(0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h200);
        wb(1, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0);
        wb(2, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        chk("mp_rv", 64'(bus.retire_valid), 2'b01);
        chk("mp_pc", 64'(bus.retire_entry[0].pc), 32'h1014);
        chk("mp_btb", 64'(bus.btb_update_valid), 1);
        chk("mp_btb_tgt", 64'(bus.btb_update_target), 32'h200);
        chk("mp_redir_pre", 64'(bus.redirect_valid), 0);
        disp(mk(OP_ALU, 32'h4000, 5'd1), mk(OP_ALU, 32'h4004, 5'd1));
        step();
        idle();
        chk("mp_redir", 64'(bus.redirect_valid), 1);
        chk("mp_redir_pc", 64'(bus.redirect_pc), 32'h200);
        chk("mp_count", 64'(bus.rob_count), 0);
        chk("mp_empty", 64'(bus.rob_empty), 1);
        step();
        chk("mp_redir_off", 64'(bus.redirect_valid), 0);
        chk("mp_no_young", 64'(bus.retire_valid), 0);

        // Two correctly predicted branches retire one per cycle
        do_reset();
        disp(mk(OP_BRANCH, 32'h2000, 5'd0), mk(OP_BRANCH, 32'h2004, 5'd0));
        step();
        idle();
        wb(0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h2100);
        wb(1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h2200);
        step();
        idle();
        chk("br_rv1", 64'(bus.retire_valid), 2'b01);
        chk("br_btb1", 64'(bus.btb_update_valid), 1);
        chk("br_pc1", 64'(bus.btb_update_pc), 32'h2000);
        chk("br_tk1", 64'(bus.btb_update_taken), 0);
        step();
        chk("br_rv2", 64'(bus.retire_valid), 2'b01);
        chk("br_btb2", 64'(bus.btb_update_valid), 1);
        chk("br_pc2", 64'(bus.btb_update_pc), 32'h2004);
        chk("br_tk2", 64'(bus.btb_update_taken), 1);
        chk("br_tgt2", 64'(bus.btb_update_target), 32'h2200);
        chk("br_redir", 64'(bus.redirect_valid), 0);
        step();
        chk("br_btb_off", 64'(bus.btb_update_valid), 0);
        chk("br_empty", 64'(bus.rob_empty), 1);

        // External flush
        do_reset();
        disp(mk(OP_ALU, 32'h500, 5'd1), mk(OP_ALU, 32'h504, 5'd1));
        step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 64'(bus.rob_count), 0);
        chk("fl_tail", 64'(bus.dispatch_rob_id[0]), 0);

        // Asynchronous reset mid-operation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            disp(mk(OP_ALU, pcs(2 * k), 5'd1), mk(OP_ALU, pcs(2 * k + 1), 5'd1));
            step();
        end
        idle();
        wb(0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        wb(1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        chk("ar_count_pre", 64'(bus.rob_count), 10);
        chk("ar_rv_pre", 64'(bus.retire_valid), 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", 64'(bus.rob_count), 0);
        chk("ar_empty", 64'(bus.rob_empty), 1);
        chk("ar_rv", 64'(bus.retire_valid), 0);
        chk("ar_btb", 64'(bus.btb_update_valid), 0);
        step();
        rst = 1'b0;
        disp(mk(OP_ALU, 32'h600, 5'd1), mk(OP_ALU, 32'h604, 5'd1));
        chk("ar_id0", 64'(bus.dispatch_rob_id[0]), 0);
        step();
        idle();
        chk("ar_count_post", 64'(bus.rob_count), 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_mw.md
Name: reorder_buffer_mw

Overview:
Parametrised multi-issue reorder buffer between rename/dispatch and architectural commit.
- Accepts up to DISPATCH_WIDTH entries per cycle and takes completion from WB_PORTS writeback ports.
- Retires up to RETIRE_WIDTH finished entries per cycle, strictly in order.
- Raises a registered redirect when a mispredicted branch/jump retires.
- Successor to the 2-wide/1-retire ROB: proper occupancy accounting on simultaneous dispatch and retire, a dispatch_ready handshake, and multi-slot retire.

Parameters:
NUM_ENTRY, 32, entry count; power of two, at least 4.
ROB_WIDTH, 5, log2(NUM_ENTRY).
DISPATCH_WIDTH, 2, dispatch slots per cycle.
RETIRE_WIDTH, 2, retire slots per cycle.
WB_PORTS, 4, writeback/complete ports.
PHY_WIDTH, 6, physical register index width.
ADDR_WIDTH, 32, PC width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  external flush; clears all state next edge
dispatch_valid  in  DISPATCH_WIDTH  per-slot valid; slots packed from bit 0 (no holes)
dispatch_entry  in  DISPATCH_WIDTH x rob_entry_t  payload (rd_arch, rd_phy_old, rd_phy_new, op class, pc)
dispatch_ready  out  1  free entries >= DISPATCH_WIDTH
dispatch_rob_id  out  DISPATCH_WIDTH x ROB_WIDTH  allocated ids, tail+i
wb_valid  in  WB_PORTS  completion valid
wb_rob_id  in  WB_PORTS x ROB_WIDTH  completing id
wb_is_ctrl  in  WB_PORTS  completion carries branch info
wb_mispredict  in  WB_PORTS  resolved mispredict
wb_taken  in  WB_PORTS  actual direction
wb_target  in  WB_PORTS x ADDR_WIDTH  actual target
retire_valid  out  RETIRE_WIDTH  slot i retires this cycle; contiguous from bit 0
retire_entry  out  RETIRE_WIDTH x rob_entry_t  retiring payloads
retire_pr_free  out  RETIRE_WIDTH  free rd_phy_old (writes rd, rd_arch != 0)
retire_store  out  RETIRE_WIDTH  retiring store
btb_update_valid  out  1  a control op retired
btb_update_pc / btb_update_taken / btb_update_target  out  ADDR_WIDTH/1/ADDR_WIDTH  BTB training
redirect_valid  out  1  registered mispredict flush request
redirect_pc  out  ADDR_WIDTH  correct fetch PC
rob_count  out  ROB_WIDTH+1  occupancy
rob_empty  out  1  count == 0

Behaviour:
- Reset (async) and flush: head = tail = count = 0; all finished and valid bits = 0; redirect_valid = 0, redirect_pc = 0. All combinational outputs read 0 when empty.
- Dispatch:
  - Accepted only when dispatch_ready = 1. Valid slots when ready = 0 are ignored; the producer holds them.
  - Accepted slot i writes entry[tail+i] and clears its finished bit. Tail advances by popcount(dispatch_valid), modulo NUM_ENTRY.
- Writeback:
  - Each valid port sets finished[id] next edge.
  - Control completions also store mispredict, taken and target.
  - Writes to an id that is not valid (stale after flush) are dropped.
  - Duplicate ids on two ports in one cycle are legal; the higher port index wins the payload.
  - Writeback to entry X and dispatch into X in the same cycle cannot occur (X is not free).
- Retire, combinational from registered state:
  - Slot i is valid iff slots 0..i-1 are valid, entry head+i is valid, and it is finished.
  - Scan stops after the first control op, so at most one BTB update per cycle.
  - Scan stops after any mispredicted entry.
  - Head advances by the number retired. A retired entry clears its valid bit.
- Count: next = count + dispatched - retired, in the same cycle; never wraps past NUM_ENTRY. dispatch_ready is combinational from the registered count.
- Mispredict:
  - When a retiring slot is mispredicted, redirect_valid = 1 for exactly one cycle after retire, with redirect_pc = target if taken, else pc+4.
  - In that same cycle all ROB state is internally cleared, as for flush.
  - Dispatch in the retire cycle is squashed.
- Priority: rst > flush > mispredict-clear > dispatch/writeback/retire.
- Wrap-around: ids are modulo NUM_ENTRY; the full case is distinguished from empty only by count.

Optional Feature:
ROB_PERF_EN
- Defined: adds outputs perf_retired (64-bit, sum of retire_valid popcounts), perf_full_cycles (32-bit, cycles with dispatch_valid != 0 and ready = 0) and perf_mispredicts (32-bit). These reset on rst only; flush does not clear them.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package rob_pkg:
  - rob_entry_t (rd_arch[4:0], rd_phy_old, rd_phy_new, op_class_t, pc).
  - op_class_t enum: ALU, LOAD, STORE, BRANCH, JUMP, SYSTEM.
  - ADDR_WIDTH constant.
- One sub-module, rob_retire_select: combinational prefix scan over RETIRE_WIDTH head entries, producing retire_valid, the stop reason and the retire count.

Test Plan:
- Reset then dispatch 2/cycle ×16 with no writeback (NUM_ENTRY=32) -> ids 0..31 allocated, rob_count=32, dispatch_ready=0 on cycle 15; the 17th pair is ignored.
- Fill 4, complete ids 3,2,1,0 in reverse order one per cycle -> no retire until id0 is finished; then retire_valid=2'b11 twice; rob_empty=1.
- Steady state: dispatch 2 and retire 2 each cycle across the wrap at 31->0 -> rob_count constant; ids wrap correctly.
- Branch at id5 completed with mispredict=1, taken=1, target=0x200, plus younger finished ids 6,7 -> id5 retires alone; next cycle redirect_valid=1, redirect_pc=0x200, rob_count=0, and ids 6,7 are never retired.
- Two non-mispredicted branches at the head, both finished -> one retires per cycle; btb_update_valid asserted on two consecutive cycles.
- rst asserted mid-operation with 10 entries occupied -> all outputs 0 asynchronously; the first dispatch after release gets id 0.
